regfile_mp: RTL
===============

# regfile_mp

Multi-read-port MIPS general-purpose register file, the parametrised successor to the datapath's two-port register file. It provides `NUM_READ` combinational read ports, one synchronous write port and a hardwired-zero register 0. It also has a sequential hardware clear engine that wipes the file one entry per cycle on request. The block sits in the datapath between instruction decode (read addresses) and write-back (write port), and supports wider-issue and debug/restart flows.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register.
- `ADDR_WIDTH`, 5, address width; `DEPTH = 1<<ADDR_WIDTH` entries.
- `NUM_READ`, 2, number of read ports (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `regWrite`  in  1  write enable.
- `writeAddr`  in  ADDR_WIDTH  write address.
- `writeData`  in  WIDTH  write data.
- `readAddr`  in  NUM_READ*ADDR_WIDTH  packed read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- `readData`  out  NUM_READ*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].
- `clearReq`  in  1  request a sequential clear of the whole file.
- `busy`  out  1  clear engine active.
- `clearDone`  out  1  one-cycle pulse when a clear completes.
- `writeDropped`  out  1  registered one-cycle pulse when a write was rejected.

## Operation
- Storage: DEPTH × WIDTH registers.
- Entry 0 always reads 0. Writes to address 0 are discarded silently and do not raise `writeDropped`.
- Reads are combinational. Each port independently returns `MEM[addr]`, or 0 for address 0.
- A write commits at the rising edge when `regWrite`=1, `writeAddr`≠0 and the FSM is in IDLE or DONE.
- Clear FSM states:
  - IDLE: `busy`=0. On `clearReq`=1, load `clrPtr`=1 and go to CLEAR.
  - CLEAR: `busy`=1. Each edge, `MEM[clrPtr]`←0. If `clrPtr`=DEPTH-1, go to DONE; otherwise `clrPtr`←`clrPtr`+1.
  - DONE: `busy`=0, `clearDone`=1 for one cycle, then go to IDLE. A `clearReq` in DONE is honoured and enters CLEAR next.
- `clearReq` is ignored while in CLEAR; it is not queued.
- Writes while in CLEAR are rejected. `writeDropped`=1 on the following cycle. This holds even if the target entry has already been cleared.
- Reads during CLEAR return current contents: cleared entries read 0, uncleared entries read their old values.
- `clearReq` and `regWrite` in the same IDLE cycle: the write commits at that edge, and clearing then wipes it.
- Reset (asynchronous): all entries 0, FSM IDLE, `clrPtr`=1, `busy`=0, `clearDone`=0, `writeDropped`=0.
- Reset asserted mid-clear aborts the clear immediately. No `clearDone` pulse is produced.

## Timing
- Read latency 0 (combinational from `readAddr` and storage).
- Write latency 1 edge: new data is visible on reads after the committing edge. With bypass, data is visible in the same cycle (see Configuration).
- Clear timeline for `clearReq` sampled at edge N:
  - `busy`=1 from after edge N.
  - Entry k is cleared at edge N+k, for k = 1..DEPTH-1.
  - `busy` falls and `clearDone` rises after edge N+DEPTH-1, and `clearDone` falls after edge N+DEPTH.
  - For DEPTH=32: `busy` is high for 31 cycles.
- `writeDropped` is high for exactly the cycle after the rejected write edge.
- `busy`, `clearDone` and `writeDropped` are driven directly from registers (no combinational path from inputs).

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: write-through forwarding. Read port p outputs `writeData` in the same cycle when all of the following hold: `regWrite`=1, `writeAddr`=`readAddr[p]`, the address is non-zero, and the FSM is not in CLEAR.
- Not defined: reads return stored contents only. A value written at edge E is first visible after E.
- Storage update, FSM and flag behaviour are identical in both builds.

## Test plan
- Reset, then write `32'hdeadbeef` to addr 10 and `32'h12345678` to addr 9. Read ports 0/1 at 10/9 -> `deadbeef`/`12345678` after the edge. Port 2 (NUM_READ=3) at 0 -> 0.
- Write `32'hffffffff` to addr 0 -> all ports read 0 at addr 0 and `writeDropped` stays 0.
- Hold `regWrite`=1 with addr 8 and data `32'hcafef00d`, port 0 reading addr 8 -> same cycle reads `cafef00d` with `REGFILE_BYPASS_EN`, and the old value (0) without it.
- Fill entries 1..31 with their index, then pulse `clearReq` -> `busy` high for 31 cycles, entry 5 reads 0 from edge N+5 while entry 20 still reads 20, and `clearDone` pulses once. Afterwards all entries read 0.
- Write addr 3 during CLEAR -> `writeDropped` pulses for one cycle and addr 3 reads 0 after the clear. A second `clearReq` mid-clear changes nothing (`busy` still 31 cycles total).
- Assert `reset` asynchronously at N+10 of a clear -> `busy`=0 immediately, no `clearDone`, all entries read 0. A subsequent write to addr 4 of `32'h1` reads back `32'h1`.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with hardwired zero and sequential clear engine
// Optional write-through read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           regWrite,
  input  logic [ADDR_WIDTH-1:0]          writeAddr,
  input  logic [WIDTH-1:0]               writeData,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddr,
  output logic [NUM_READ*WIDTH-1:0]      readData,
  input  logic                           clearReq,
  output logic                           busy,
  output logic                           clearDone,
  output logic                           writeDropped
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dropped_q, dropped_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  in_clear;
  logic                  wr_nonzero;
  logic                  wr_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  assign in_clear   = (state_q == S_CLEAR);
  assign wr_nonzero = regWrite && (writeAddr != '0);
  assign wr_ok      = wr_nonzero && !in_clear;

  // The clear engine and the user write never compete: user writes are refused while clearing.
  assign mem_we    = wr_ok || in_clear;
  assign mem_waddr = in_clear ? clr_ptr_q : writeAddr;
  assign mem_wdata = in_clear ? '0 : writeData;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dropped_d = wr_nonzero && in_clear;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (clearReq) begin
          state_d   = S_CLEAR;
          clr_ptr_d = FIRST_ADDR;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + FIRST_ADDR;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      clr_ptr_q <= FIRST_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign busy         = busy_q;
  assign clearDone    = done_q;
  assign writeDropped = dropped_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] raddr;
    logic [WIDTH-1:0]      rdata;

    assign raddr = readAddr[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdata = (raddr == '0) ? '0 : mem_q[raddr];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (writeAddr == raddr)) begin
        rdata = writeData;
      end
`endif
    end

    assign readData[p*WIDTH +: WIDTH] = rdata;
  end

endmodule
